uart_cmd_parser: RTL and testbench



---
 rtl/uart_cmd_parser.sv | 155 +++++++++++++++
 tb/tb_uart_cmd_parser.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
//   Turns the ASCII byte stream from the UART receiver into calculator
//   commands. Decimal digits build an operand. SPACE latches the operand.
//   Each operation letter after that issues one command through a
//   valid/ready handshake. Errors are reported as a one-cycle pulse with a
//   cause code. All outputs are registered.
//
//   state | meaning
//   IDLE  | nothing held
//   NUM   | accumulating decimal digits
//   ARMED | operand latched, waiting for operation letters
//   OUT   | command presented, cmd_valid high
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   rx_data     received ASCII byte
//   rx_valid    single-cycle strobe qualifying rx_data
//   cmd_ready   calculator stage accepts the command
//   cmd_valid   command available
//   cmd_op      00 sqrt, 01 sin, 10 cos, 11 prime
//   cmd_operand operand for the command
//   err_valid   one-cycle error pulse
//   err_code    01 overflow, 10 no operand, 11 busy
//   armed       an operand is latched and ready for operation letters
module uart_cmd_parser #(
   parameter int OPERAND_W   = 9,
   parameter int OPERAND_MAX = 511,
   parameter int MAX_DIGITS  = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [7:0]           rx_data,
   input  logic                 rx_valid,
   input  logic                 cmd_ready,
   output logic                 cmd_valid,
   output logic [1:0]           cmd_op,
   output logic [OPERAND_W-1:0] cmd_operand,
   output logic                 err_valid,
   output logic [1:0]           err_code,
   output logic                 armed
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_NUM   = 2'd1;
   localparam logic [1:0] ST_ARMED = 2'd2;
   localparam logic [1:0] ST_OUT   = 2'd3;

   localparam logic [1:0] ERR_OVERFLOW = 2'b01;
   localparam logic [1:0] ERR_NO_OPND  = 2'b10;
   localparam logic [1:0] ERR_BUSY     = 2'b11;

   localparam int CNT_W  = $clog2(MAX_DIGITS + 1);
   // Wide enough for OPERAND_MAX*10 + 9 without wrap.
   localparam int NEXT_W = OPERAND_W + 4;

   logic [1:0]           state;
   logic [OPERAND_W-1:0] acc;
   logic [CNT_W-1:0]     cnt;
   logic [OPERAND_W-1:0] operand_reg;

   logic              is_digit;
   logic              is_space;
   logic              is_op;
   logic              is_esc;
   logic [1:0]        op_code;
   logic [NEXT_W-1:0] next_val;
   logic              digit_err;

   always_comb begin
      is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
      is_space = (rx_data == 8'h20);
      is_esc   = (rx_data == 8'h1B);
      is_op    = 1'b1;
      op_code  = 2'b00;
      case (rx_data)
         8'h51, 8'h71: op_code = 2'b00;   // Q q
         8'h42, 8'h62: op_code = 2'b01;   // B b
         8'h43, 8'h63: op_code = 2'b10;   // C c
         8'h50, 8'h70: op_code = 2'b11;   // P p
         default:      is_op   = 1'b0;
      endcase
      next_val  = NEXT_W'(acc) * NEXT_W'(10) + NEXT_W'(rx_data[3:0]);
      digit_err = (cnt == CNT_W'(MAX_DIGITS)) || (next_val > NEXT_W'(OPERAND_MAX));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         acc         <= '0;
         cnt         <= '0;
         operand_reg <= '0;
         cmd_valid   <= 1'b0;
         cmd_op      <= 2'b00;
         cmd_operand <= '0;
         err_valid   <= 1'b0;
         err_code    <= 2'b00;
         armed       <= 1'b0;
      end else begin
         err_valid <= 1'b0;
         if (state == ST_OUT) begin
            if (cmd_ready) begin
               cmd_valid <= 1'b0;
               state     <= ST_ARMED;
            end
            // Any meaningful byte is dropped while a command is pending,
            // including one arriving on the handshake cycle itself.
            if (rx_valid && (is_digit || is_space || is_op || is_esc)) begin
               err_valid <= 1'b1;
               err_code  <= ERR_BUSY;
            end
         end else if (rx_valid) begin
            if (is_digit) begin
               armed <= 1'b0;
               if (digit_err) begin
                  err_valid <= 1'b1;
                  err_code  <= ERR_OVERFLOW;
                  acc       <= '0;
                  cnt       <= '0;
                  state     <= ST_IDLE;
               end else begin
                  acc   <= next_val[OPERAND_W-1:0];
                  cnt   <= cnt + CNT_W'(1);
                  state <= ST_NUM;
               end
            end else if (is_space) begin
               if (state == ST_NUM) begin
                  operand_reg <= acc;
                  acc         <= '0;
                  cnt         <= '0;
                  state       <= ST_ARMED;
                  armed       <= 1'b1;
               end
            end else if (is_op) begin
               if (state == ST_ARMED) begin
                  cmd_op      <= op_code;
                  cmd_operand <= operand_reg;
                  cmd_valid   <= 1'b1;
                  state       <= ST_OUT;
               end else begin
                  err_valid <= 1'b1;
                  err_code  <= ERR_NO_OPND;
               end
            end else if (is_esc) begin
               acc         <= '0;
               cnt         <= '0;
               operand_reg <= '0;
               armed       <= 1'b0;
               state       <= ST_IDLE;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_cmd_parser.sv
module tb_uart_cmd_parser;

   logic       clk;
   logic       reset;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       cmd_ready;
   logic       cmd_valid;
   logic [1:0] cmd_op;
   logic [8:0] cmd_operand;
   logic       err_valid;
   logic [1:0] err_code;
   logic       armed;

   int passed = 0;
   int total  = 0;

   uart_cmd_parser dut (
      .clk         (clk),
      .reset       (reset),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .cmd_ready   (cmd_ready),
      .cmd_valid   (cmd_valid),
      .cmd_op      (cmd_op),
      .cmd_operand (cmd_operand),
      .err_valid   (err_valid),
      .err_code    (err_code),
      .armed       (armed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Called at a negedge; strobes one byte across the next posedge and
   // returns at the following negedge, where registered results are visible.
   task automatic send(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   initial begin
      reset     = 1'b1;
      rx_data   = 8'h00;
      rx_valid  = 1'b0;
      cmd_ready = 1'b1;
      idle(2);
      check("rst_cmd_valid", int'(cmd_valid), 0);
      check("rst_err_valid", int'(err_valid), 0);
      check("rst_armed", int'(armed), 0);
      check("rst_operand", int'(cmd_operand), 0);
      reset = 1'b0;
      idle(1);

      // "123 Q" with ready high
      send("1"); send("2"); send("3");
      check("t1_not_armed_yet", int'(armed), 0);
      send(" ");
      check("t1_armed", int'(armed), 1);
      send("Q");
      check("t1_valid", int'(cmd_valid), 1);
      check("t1_op", int'(cmd_op), 0);
      check("t1_operand", int'(cmd_operand), 123);
      check("t1_no_err", int'(err_valid), 0);
      idle(1);
      check("t1_valid_drop", int'(cmd_valid), 0);
      check("t1_armed_after", int'(armed), 1);

      // "512" overflow, then 'B' with no operand
      send("5");
      check("t2_armed_drop", int'(armed), 0);
      send("1"); send("2");
      check("t2_err", int'(err_valid), 1);
      check("t2_code", int'(err_code), 1);
      idle(1);
      check("t2_err_pulse", int'(err_valid), 0);
      send("B");
      check("t2_noop_err", int'(err_valid), 1);
      check("t2_noop_code", int'(err_code), 2);
      check("t2_no_cmd", int'(cmd_valid), 0);

      // ignored byte in IDLE
      send("x");
      check("ign_no_err", int'(err_valid), 0);

      // "90 C" with ready low, 'P' while busy
      cmd_ready = 1'b0;
      send("9"); send("0"); send(" "); send("C");
      check("t3_valid", int'(cmd_valid), 1);
      check("t3_op", int'(cmd_op), 2);
      check("t3_operand", int'(cmd_operand), 90);
      send("P");
      check("t3_busy_err", int'(err_valid), 1);
      check("t3_busy_code", int'(err_code), 3);
      check("t3_hold_op", int'(cmd_op), 2);
      idle(3);
      check("t3_hold_valid", int'(cmd_valid), 1);
      check("t3_hold_operand", int'(cmd_operand), 90);
      cmd_ready = 1'b1;
      idle(1);
      check("t3_hs_done", int'(cmd_valid), 0);
      check("t3_armed", int'(armed), 1);
      send("P");
      check("t3_p_valid", int'(cmd_valid), 1);
      check("t3_p_op", int'(cmd_op), 3);
      check("t3_p_operand", int'(cmd_operand), 90);
      idle(1);

      // byte on the handshake cycle is still busy
      cmd_ready = 1'b0;
      send("q");
      check("hsb_valid", int'(cmd_valid), 1);
      cmd_ready = 1'b1;
      send("B");
      check("hsb_err", int'(err_valid), 1);
      check("hsb_code", int'(err_code), 3);
      check("hsb_done", int'(cmd_valid), 0);

      // four digits with leading zeros overflow
      send("0"); send("0"); send("0");
      check("t4_no_err_3", int'(err_valid), 0);
      send("7");
      check("t4_err", int'(err_valid), 1);
      check("t4_code", int'(err_code), 1);
      send("7"); send(" "); send("b");
      check("t4_valid", int'(cmd_valid), 1);
      check("t4_op", int'(cmd_op), 1);
      check("t4_operand", int'(cmd_operand), 7);
      idle(1);

      // upper bound accepted
      send("5"); send("1"); send("1");
      check("max_no_err", int'(err_valid), 0);
      send(" "); send("p");
      check("max_op", int'(cmd_op), 3);
      check("max_operand", int'(cmd_operand), 511);
      idle(1);

      // ESC discards a latched operand
      send("4"); send("5"); send(" ");
      check("t5_armed", int'(armed), 1);
      send(8'h1B);
      check("t5_esc_armed", int'(armed), 0);
      send("Q");
      check("t5_err", int'(err_valid), 1);
      check("t5_code", int'(err_code), 2);
      check("t5_no_cmd", int'(cmd_valid), 0);

      // async reset while in OUT with an error pulse outstanding
      cmd_ready = 1'b0;
      send("1"); send(" "); send("Q");
      check("t6_in_out", int'(cmd_valid), 1);
      send("B");
      check("t6_err_before", int'(err_valid), 1);
      #1 reset = 1'b1;
      #1;
      check("t6_rst_valid", int'(cmd_valid), 0);
      check("t6_rst_operand", int'(cmd_operand), 0);
      check("t6_rst_armed", int'(armed), 0);
      check("t6_rst_err", int'(err_valid), 0);
      @(negedge clk);
      reset     = 1'b0;
      cmd_ready = 1'b1;
      idle(1);
      send("Q");
      check("t6_post_err", int'(err_valid), 1);
      check("t6_post_code", int'(err_code), 2);
      check("t6_post_no_cmd", int'(cmd_valid), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
